alu_op_sequencer: RTL and testbench

- Issue and writeback controller for the nibble-serial 8-bit ALU (alu_mod).
- Accepts one ALU request from the CPU decode stage and drives the ALU operands, opcode and carry-in, holding them stable for both ALU phases.
- Captures the 8-bit result and partial flags, then merges them into the architectural F register with Game Boy Z/N/H/C semantics.
- Owns F[7:4]; emits a result write strobe toward the register file.

---
 rtl/gb_alu_pkg.sv | 32 +++
 rtl/alu_flag_merge.sv | 36 +++
 rtl/alu_op_sequencer.sv | 91 +++++++++
 tb/tb_alu_op_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_alu_pkg.sv
// Shared definitions for the nibble-serial ALU issue path: opcodes, flag bit
// positions and sequencer states.
package gb_alu_pkg;

   typedef enum logic [2:0] {
      ADD_OP = 3'd0,
      ADC_OP = 3'd1,
      SUB_OP = 3'd2,
      SBC_OP = 3'd3,
      AND_OP = 3'd4,
      XOR_OP = 3'd5,
      OR_OP  = 3'd6,
      CP_OP  = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2
   } seq_state_e;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_H = 1;
   localparam int FLAG_C = 0;

   // Subtract-class ops set N and may need their carry turned into a borrow.
   function automatic logic is_sub_class(input alu_op_e op);
      return (op == SUB_OP) || (op == SBC_OP) || (op == CP_OP);
   endfunction

endpackage

// File: rtl/alu_flag_merge.sv
// Turns the ALU's partial {Z,0,H,C} flags into architectural Z/N/H/C for the
// given opcode. Purely combinational so the 16-bit ADD HL path can share it.
module alu_flag_merge
   import gb_alu_pkg::*;
#(
   parameter bit SUB_C_IS_BORROW = 1'b1
) (
   input  alu_op_e    op,
   input  logic [3:0] alu_flags,
   output logic [3:0] flags
);

   // The ALU always drives its N slot as 0; N comes from the opcode instead.
   logic unused_alu_n;
   assign unused_alu_n = alu_flags[FLAG_N];

   always_comb begin
      // NOTE: defaulting every bit first keeps this block latch-free no matter which case arm runs.
      flags         = '0;
      flags[FLAG_Z] = alu_flags[FLAG_Z];
      flags[FLAG_N] = is_sub_class(op);
      case (op)
         ADD_OP, ADC_OP: begin
            flags[FLAG_H] = alu_flags[FLAG_H];
            flags[FLAG_C] = alu_flags[FLAG_C];
         end
         SUB_OP, SBC_OP, CP_OP: begin
            flags[FLAG_H] = alu_flags[FLAG_H];
            flags[FLAG_C] = alu_flags[FLAG_C] ^ ~SUB_C_IS_BORROW;
         end
         AND_OP:  flags[FLAG_H] = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one request to the nibble-serial ALU, holds operands over its low and
// high phases, then writes back the result and the merged F[7:4] flags.
module alu_op_sequencer
   import gb_alu_pkg::*;
#(
   parameter logic [3:0] F_RESET         = 4'b1011,
   parameter bit         SUB_C_IS_BORROW = 1'b1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   output logic       ready,
   input  logic [2:0] op,
   input  logic [7:0] opnd_a,
   input  logic [7:0] opnd_b,
   input  logic       f_load,
   input  logic [3:0] f_in,
   output logic [7:0] alu_in_A,
   output logic [7:0] alu_in_B,
   output logic [2:0] alu_op,
   output logic       alu_in_C,
   input  logic [7:0] alu_out,
   input  logic [3:0] alu_flags,
   output logic [7:0] result,
   output logic [3:0] flags,
   output logic       done,
   output logic       wb_en
);

   seq_state_e state;
   logic       phase;
   alu_op_e    op_q;
   logic [3:0] merged_flags;

   alu_flag_merge #(
      .SUB_C_IS_BORROW(SUB_C_IS_BORROW)
   ) u_flag_merge (
      .op        (op_q),
      .alu_flags (alu_flags),
      .flags     (merged_flags)
   );

   // Accepting only on phase 1 makes LO land on the ALU's low-nibble phase.
   assign ready  = (state == IDLE) && phase;
   assign alu_op = op_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         phase    <= 1'b0;
         op_q     <= ADD_OP;
         alu_in_A <= 8'h00;
         alu_in_B <= 8'h00;
         alu_in_C <= 1'b0;
         result   <= 8'h00;
         flags    <= F_RESET;
         done     <= 1'b0;
         wb_en    <= 1'b0;
      end else begin
         // NOTE: non-blocking here so every register samples pre-edge values, matching real flops.
         phase <= ~phase;
         done  <= 1'b0;
         wb_en <= 1'b0;
         if (f_load)
            flags <= f_in;
         case (state)
            IDLE: begin
               if (start && ready) begin
                  state    <= LO;
                  op_q     <= alu_op_e'(op);
                  alu_in_A <= opnd_a;
                  alu_in_B <= opnd_b;
                  alu_in_C <= flags[FLAG_C];
               end
            end
            LO: state <= HI;
            HI: begin
               // Completion overrides a simultaneous f_load because it is assigned last.
               state <= IDLE;
               flags <= merged_flags;
               if (op_q != CP_OP)
                  result <= alu_out;
               done  <= 1'b1;
               wb_en <= (op_q != CP_OP);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small nibble-serial ALU stand-in
// driving alu_out/alu_flags from the sequencer's ALU-side outputs.
module tb_alu_op_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       start;
   logic       ready;
   logic [2:0] op;
   logic [7:0] opnd_a;
   logic [7:0] opnd_b;
   logic       f_load;
   logic [3:0] f_in;
   logic [7:0] alu_in_A;
   logic [7:0] alu_in_B;
   logic [2:0] alu_op;
   logic       alu_in_C;
   logic [7:0] alu_out;
   logic [3:0] alu_flags;
   logic [7:0] result;
   logic [3:0] flags;
   logic       done;
   logic       wb_en;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   alu_op_sequencer #(
      .F_RESET         (4'b1011),
      .SUB_C_IS_BORROW (1'b1)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .ready     (ready),
      .op        (op),
      .opnd_a    (opnd_a),
      .opnd_b    (opnd_b),
      .f_load    (f_load),
      .f_in      (f_in),
      .alu_in_A  (alu_in_A),
      .alu_in_B  (alu_in_B),
      .alu_op    (alu_op),
      .alu_in_C  (alu_in_C),
      .alu_out   (alu_out),
      .alu_flags (alu_flags),
      .result    (result),
      .flags     (flags),
      .done      (done),
      .wb_en     (wb_en)
   );

   // Stand-in ALU: low nibble registered at the end of phase 0, high nibble
   // combinational during phase 1 using the registered half carry/borrow.
   logic       alu_ph;
   logic [3:0] lo_q;
   logic       hc_q;
   logic [4:0] hi_w;
   logic       cin_lo;

   function automatic logic [4:0] nib(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
      case (o)
         3'd0, 3'd1:       return {1'b0, x} + {1'b0, y} + {4'b0, ci};
         3'd2, 3'd3, 3'd7: return {1'b0, x} - {1'b0, y} - {4'b0, ci};
         3'd4:             return {1'b0, x & y};
         3'd5:             return {1'b0, x ^ y};
         default:          return {1'b0, x | y};
      endcase
   endfunction

   assign cin_lo    = ((alu_op == 3'd1) || (alu_op == 3'd3)) ? alu_in_C : 1'b0;
   assign hi_w      = nib(alu_op, alu_in_A[7:4], alu_in_B[7:4], hc_q);
   assign alu_out   = {hi_w[3:0], lo_q};
   assign alu_flags = {alu_out == 8'h00, 1'b0, hc_q, hi_w[4]};

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alu_ph <= 1'b0;
         lo_q   <= 4'h0;
         hc_q   <= 1'b0;
      end else begin
         alu_ph <= ~alu_ph;
         if (!alu_ph)
            {hc_q, lo_q} <= nib(alu_op, alu_in_A[3:0], alu_in_B[3:0], cin_lo);
      end
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 8 && !ready; i++)
         @(negedge clock);
      check("ready_wait", 8'(ready), 8'h01);
   endtask

   // fl_stage: 0 no f_load, 1 f_load during LO, 2 f_load during HI (completion edge).
   task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic exp_c, input logic [7:0] exp_res, input logic [3:0] exp_f,
                        input logic exp_wb, input int fl_stage, input logic [3:0] fl_val);
      wait_ready();
      op     = o;
      opnd_a = a;
      opnd_b = b;
      start  = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      if (fl_stage == 1) begin
         f_load = 1'b1;
         f_in   = fl_val;
      end
      @(negedge clock);
      check("lo_alu_in_A", alu_in_A, a);
      check("lo_alu_in_B", alu_in_B, b);
      check("lo_alu_op", 8'(alu_op), 8'(o));
      check("lo_alu_in_C", 8'(alu_in_C), 8'(exp_c));
      check("lo_ready", 8'(ready), 8'h00);
      @(posedge clock);
      #1 f_load = 1'b0;
      if (fl_stage == 2) begin
         f_load = 1'b1;
         f_in   = fl_val;
      end
      @(negedge clock);
      check("hi_done", 8'(done), 8'h00);
      check("hi_alu_in_C", 8'(alu_in_C), 8'(exp_c));
      @(posedge clock);
      #1 f_load = 1'b0;
      @(negedge clock);
      check("done", 8'(done), 8'h01);
      check("wb_en", 8'(wb_en), 8'(exp_wb));
      check("result", result, exp_res);
      check("flags", 8'(flags), 8'(exp_f));
      @(negedge clock);
      check("done_pulse", 8'(done), 8'h00);
      check("wb_pulse", 8'(wb_en), 8'h00);
      check("ready_next", 8'(ready), 8'h01);
   endtask

   initial begin
      int n_acc;
      int last;
      int n_done;

      reset_n = 1'b0;
      start   = 1'b0;
      op      = 3'd0;
      opnd_a  = 8'h00;
      opnd_b  = 8'h00;
      f_load  = 1'b0;
      f_in    = 4'h0;
      repeat (3) @(negedge clock);
      check("rst_ready", 8'(ready), 8'h00);
      check("rst_flags", 8'(flags), 8'h0B);
      check("rst_result", result, 8'h00);
      check("rst_done", 8'(done), 8'h00);
      check("rst_alu_in_A", alu_in_A, 8'h00);
      reset_n = 1'b1;
      @(negedge clock);
      check("first_ready", 8'(ready), 8'h01);

      do_op(3'd0, 8'h3A, 8'hC6, 1'b1, 8'h00, 4'b1011, 1'b1, 0, 4'h0);  // add
      do_op(3'd1, 8'hE1, 8'h0F, 1'b1, 8'hF1, 4'b0010, 1'b1, 0, 4'h0);  // adc, C=1
      do_op(3'd2, 8'h3E, 8'h3E, 1'b0, 8'h00, 4'b1100, 1'b1, 0, 4'h0);  // sub
      do_op(3'd4, 8'h5A, 8'h3F, 1'b0, 8'h1A, 4'b0010, 1'b1, 0, 4'h0);  // and
      do_op(3'd7, 8'h3C, 8'h2F, 1'b0, 8'h1A, 4'b0110, 1'b0, 0, 4'h0);  // cp keeps result
      do_op(3'd6, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000, 1'b1, 0, 4'h0);  // or -> zero

      // Direct flag load while idle.
      f_load = 1'b1;
      f_in   = 4'b0001;
      @(posedge clock);
      #1 f_load = 1'b0;
      @(negedge clock);
      check("f_load_idle", 8'(flags), 8'h01);

      // sbc with borrow-in; an f_load during LO must not disturb the latched C.
      do_op(3'd3, 8'h10, 8'h01, 1'b1, 8'h0E, 4'b0110, 1'b1, 1, 4'b0000);
      do_op(3'd5, 8'h0F, 8'hF0, 1'b0, 8'hFF, 4'b0000, 1'b1, 0, 4'h0);  // xor

      // start held high: accepts must be exactly 4 cycles apart.
      wait_ready();
      op     = 3'd0;
      opnd_a = 8'h01;
      opnd_b = 8'h01;
      start  = 1'b1;
      n_acc  = 0;
      n_done = 0;
      last   = 0;
      for (int i = 0; i < 16; i++) begin
         if (ready && start) begin
            if (n_acc > 0)
               check("accept_spacing", 8'(i - last), 8'd4);
            last = i;
            n_acc++;
         end
         if (done)
            n_done++;
         @(negedge clock);
      end
      start = 1'b0;
      check("accept_count", 8'(n_acc), 8'd4);
      check("done_count", 8'(n_done), 8'd4);
      check("held_result", result, 8'h02);

      // f_load on the completion edge loses to the completion update.
      do_op(3'd0, 8'h01, 8'h01, 1'b0, 8'h02, 4'b0000, 1'b1, 2, 4'b0001);

      // Reset asserted while in HI aborts the operation.
      wait_ready();
      op     = 3'd0;
      opnd_a = 8'h7F;
      opnd_b = 8'h01;
      start  = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      check("abort_ready", 8'(ready), 8'h00);
      check("abort_flags", 8'(flags), 8'h0B);
      check("abort_result", result, 8'h00);
      check("abort_done", 8'(done), 8'h00);
      check("abort_wb_en", 8'(wb_en), 8'h00);
      n_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (done)
            n_done++;
      end
      reset_n = 1'b1;
      #1 check("release_ready", 8'(ready), 8'h00);
      @(negedge clock);
      if (done)
         n_done++;
      check("abort_no_done", 8'(n_done), 8'h00);
      check("release_first_ready", 8'(ready), 8'h01);

      do_op(3'd0, 8'h3A, 8'hC6, 1'b1, 8'h00, 4'b1011, 1'b1, 0, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected $finish");
      $fatal(1, "bench timeout");
   end

endmodule
